// File: rtl/dog_game_pkg.sv
// Shared constants and types for the dog update sequencer.
package dog_game_pkg;

  localparam int N_DOGS = 4;
  localparam int IDX_W  = 2;
  localparam int OVR_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    REQ  = 2'd2,
    WAIT = 2'd3
  } sched_state_t;

endpackage

// File: rtl/dog_prio_enc.sv
// Lowest-set-bit encoder: returns the index of the lowest set bit of mask (0 if none).
module dog_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] mask,
  output logic [W-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/dog_update_sched.sv
// Per-frame sequencer: walks the snapshotted enabled-dog mask, one shared update per dog,
// with a stall timeout and a saturating count of frame ticks dropped while busy.
module dog_update_sched #(
  parameter int N_DOGS  = dog_game_pkg::N_DOGS,
  parameter int IDX_W   = dog_game_pkg::IDX_W,
  parameter int TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_tick,
  input  logic [N_DOGS-1:0]              dog_enable,
  output logic                           upd_req,
  output logic [IDX_W-1:0]               upd_idx,
  input  logic                           upd_ack,
  input  logic                           upd_done,
  output logic                           wr_en,
  output logic [IDX_W-1:0]               wr_idx,
  output logic                           busy,
  output logic                           frame_done,
  output logic [dog_game_pkg::OVR_W-1:0] overrun_cnt,
  output logic                           timeout_err
);

  import dog_game_pkg::*;

  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [OVR_W-1:0]   OVR_MAX    = '1;

  sched_state_t        state, state_nxt;
  logic [N_DOGS-1:0]   pend_mask, pend_nxt, clr_mask;
  logic [TIMER_W-1:0]  timer, timer_nxt;
  logic [IDX_W-1:0]    low_idx, upd_idx_nxt, wr_idx_nxt;
  logic                upd_req_nxt, wr_en_nxt, frame_done_nxt, timeout_nxt;
  logic [OVR_W-1:0]    ovr_nxt;

  dog_prio_enc #(.N(N_DOGS), .W(IDX_W)) u_prio_enc (
    .mask (pend_mask),
    .idx  (low_idx)
  );

  // Pending mask with the dog currently being serviced removed.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N_DOGS; i++) begin
      clr_mask[i] = pend_mask[i] & (upd_idx != IDX_W'(i));
    end
  end

  always_comb begin
    state_nxt      = state;
    pend_nxt       = pend_mask;
    timer_nxt      = timer;
    upd_req_nxt    = upd_req;
    upd_idx_nxt    = upd_idx;
    wr_en_nxt      = 1'b0;
    wr_idx_nxt     = wr_idx;
    frame_done_nxt = 1'b0;
    timeout_nxt    = timeout_err;
    ovr_nxt        = overrun_cnt;

    if (frame_tick && (state != IDLE) && (overrun_cnt != OVR_MAX)) begin
      ovr_nxt = overrun_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (frame_tick) begin
          if (|dog_enable) begin
            pend_nxt  = dog_enable;
            state_nxt = SCAN;
          end else begin
            frame_done_nxt = 1'b1;
          end
        end
      end
      SCAN: begin
        upd_idx_nxt = low_idx;
        timer_nxt   = '0;
        upd_req_nxt = 1'b1;
        state_nxt   = REQ;
      end
      REQ: begin
        timer_nxt = timer + 1'b1;
        if (timer == TIMER_LAST) begin
          timeout_nxt    = 1'b1;
          upd_req_nxt    = 1'b0;
          pend_nxt       = clr_mask;
          state_nxt      = (|clr_mask) ? SCAN : IDLE;
          frame_done_nxt = ~(|clr_mask);
        end else if (upd_ack) begin
          upd_req_nxt = 1'b0;
          state_nxt   = WAIT;
        end
      end
      WAIT: begin
        timer_nxt = timer + 1'b1;
        // A done in the timeout cycle still wins and gets written back.
        if (upd_done || (timer == TIMER_LAST)) begin
          wr_en_nxt      = upd_done;
          wr_idx_nxt     = upd_done ? upd_idx : wr_idx;
          timeout_nxt    = timeout_err | ~upd_done;
          upd_req_nxt    = 1'b0;
          pend_nxt       = clr_mask;
          state_nxt      = (|clr_mask) ? SCAN : IDLE;
          frame_done_nxt = ~(|clr_mask);
        end
      end
      default: begin
        state_nxt   = IDLE;
        upd_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend_mask   <= '0;
      timer       <= '0;
      upd_req     <= 1'b0;
      upd_idx     <= '0;
      wr_en       <= 1'b0;
      wr_idx      <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend_mask   <= pend_nxt;
      timer       <= timer_nxt;
      upd_req     <= upd_req_nxt;
      upd_idx     <= upd_idx_nxt;
      wr_en       <= wr_en_nxt;
      wr_idx      <= wr_idx_nxt;
      busy        <= (state_nxt != IDLE);
      frame_done  <= frame_done_nxt;
      overrun_cnt <= ovr_nxt;
      timeout_err <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_dog_update_sched.sv
// Directed bench for dog_update_sched: a responder acks each request at once and returns
// done one cycle later (except for skip_idx); each task checks its scenario cycle by cycle.
module tb_dog_update_sched;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic [3:0] dog_enable;
  logic       upd_req;
  logic [1:0] upd_idx;
  logic       upd_ack;
  logic       upd_done;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic       busy;
  logic       frame_done;
  logic [7:0] overrun_cnt;
  logic       timeout_err;

  logic [2:0] skip_idx;
  int         n_cmp;
  int         n_err;

  dog_update_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .dog_enable  (dog_enable),
    .upd_req     (upd_req),
    .upd_idx     (upd_idx),
    .upd_ack     (upd_ack),
    .upd_done    (upd_done),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun_cnt (overrun_cnt),
    .timeout_err (timeout_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // update-unit responder
  initial begin
    upd_ack  = 1'b0;
    upd_done = 1'b0;
    forever begin
      @(negedge clk);
      upd_done = upd_ack && ({1'b0, upd_idx} != skip_idx);
      upd_ack  = upd_req && !upd_ack;
    end
  end

  task automatic start_frame(input logic [3:0] mask);
    @(negedge clk);
    dog_enable = mask;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    if ({upd_req, upd_idx, wr_en, wr_idx, busy, frame_done, overrun_cnt, timeout_err} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h exp=0",
               {upd_req, upd_idx, wr_en, wr_idx, busy, frame_done, overrun_cnt, timeout_err});
    end
    n_cmp++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_mask;
    logic       exp_wr, exp_req, exp_busy;
    logic [1:0] exp_i;
    start_frame(4'b1111);
    for (int k = 1; k <= 16; k++) begin
      exp_wr   = (k == 4) || (k == 7) || (k == 10) || (k == 13);
      exp_req  = (k == 2) || (k == 5) || (k == 8) || (k == 11);
      exp_busy = (k >= 1) && (k <= 12);
      if (wr_en !== exp_wr) begin
        n_err++; $display("FAIL full wr_en cyc=%0d got=%b exp=%b", k, wr_en, exp_wr);
      end
      n_cmp++;
      if (exp_wr) begin
        exp_i = 2'((k - 4) / 3);
        if (wr_idx !== exp_i) begin
          n_err++; $display("FAIL full wr_idx cyc=%0d got=%0d exp=%0d", k, wr_idx, exp_i);
        end
        n_cmp++;
      end
      if (upd_req !== exp_req) begin
        n_err++; $display("FAIL full upd_req cyc=%0d got=%b exp=%b", k, upd_req, exp_req);
      end
      n_cmp++;
      if (exp_req) begin
        exp_i = 2'((k - 2) / 3);
        if (upd_idx !== exp_i) begin
          n_err++; $display("FAIL full upd_idx cyc=%0d got=%0d exp=%0d", k, upd_idx, exp_i);
        end
        n_cmp++;
      end
      if (frame_done !== (k == 13)) begin
        n_err++; $display("FAIL full frame_done cyc=%0d got=%b exp=%b", k, frame_done, (k == 13));
      end
      n_cmp++;
      if (busy !== exp_busy) begin
        n_err++; $display("FAIL full busy cyc=%0d got=%b exp=%b", k, busy, exp_busy);
      end
      n_cmp++;
      @(negedge clk);
    end
  endtask

  task automatic test_sparse_mask;
    int n_wr;
    logic exp_wr;
    n_wr = 0;
    start_frame(4'b1010);
    dog_enable = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      exp_wr = (k == 4) || (k == 7);
      if (wr_en) n_wr++;
      if (wr_en !== exp_wr) begin
        n_err++; $display("FAIL sparse wr_en cyc=%0d got=%b exp=%b", k, wr_en, exp_wr);
      end
      n_cmp++;
      if (k == 4 && wr_idx !== 2'd1) begin
        n_err++; $display("FAIL sparse wr_idx_first got=%0d exp=1", wr_idx);
      end
      if (k == 7 && wr_idx !== 2'd3) begin
        n_err++; $display("FAIL sparse wr_idx_second got=%0d exp=3", wr_idx);
      end
      if (k == 4 || k == 7) n_cmp++;
      if ((k == 2 || k == 5) && (upd_req !== 1'b1 || upd_idx !== ((k == 2) ? 2'd1 : 2'd3))) begin
        n_err++; $display("FAIL sparse request cyc=%0d got req=%b idx=%0d", k, upd_req, upd_idx);
      end
      if (k == 2 || k == 5) n_cmp++;
      if (frame_done !== (k == 7)) begin
        n_err++; $display("FAIL sparse frame_done cyc=%0d got=%b exp=%b", k, frame_done, (k == 7));
      end
      n_cmp++;
      @(negedge clk);
    end
    if (n_wr != 2) begin
      n_err++; $display("FAIL sparse wr_count got=%0d exp=2", n_wr);
    end
    n_cmp++;
  endtask

  task automatic test_empty_mask;
    start_frame(4'b0000);
    for (int k = 1; k <= 3; k++) begin
      if (frame_done !== (k == 1)) begin
        n_err++; $display("FAIL empty frame_done cyc=%0d got=%b exp=%b", k, frame_done, (k == 1));
      end
      if (upd_req !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL empty req_busy cyc=%0d got req=%b busy=%b exp 0/0", k, upd_req, busy);
      end
      n_cmp += 2;
      @(negedge clk);
    end
  endtask

  task automatic test_timeout;
    logic exp_wr;
    skip_idx = 3'd2;
    start_frame(4'b0110);
    for (int k = 1; k <= 72; k++) begin
      exp_wr = (k == 4);
      if (wr_en !== exp_wr) begin
        n_err++; $display("FAIL timeout wr_en cyc=%0d got=%b exp=%b", k, wr_en, exp_wr);
      end
      n_cmp++;
      if (exp_wr && wr_idx !== 2'd1) begin
        n_err++; $display("FAIL timeout wr_idx got=%0d exp=1", wr_idx);
      end
      if (exp_wr) n_cmp++;
      if (timeout_err !== (k >= 69)) begin
        n_err++; $display("FAIL timeout timeout_err cyc=%0d got=%b exp=%b", k, timeout_err, (k >= 69));
      end
      n_cmp++;
      if (frame_done !== (k == 69)) begin
        n_err++; $display("FAIL timeout frame_done cyc=%0d got=%b exp=%b", k, frame_done, (k == 69));
      end
      n_cmp++;
      if (busy !== (k <= 68)) begin
        n_err++; $display("FAIL timeout busy cyc=%0d got=%b exp=%b", k, busy, (k <= 68));
      end
      n_cmp++;
      @(negedge clk);
    end
    skip_idx = 3'd4;
  endtask

  task automatic test_reset_mid_frame;
    bit seen;
    start_frame(4'b1111);
    repeat (5) @(negedge clk);
    if (upd_req !== 1'b0 || upd_idx !== 2'd1 || busy !== 1'b1) begin
      n_err++; $display("FAIL rstmid wait_idx1 got req=%b idx=%0d busy=%b exp 0/1/1", upd_req, upd_idx, busy);
    end
    n_cmp++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    if ({upd_req, upd_idx, wr_en, wr_idx, busy, frame_done, overrun_cnt, timeout_err} !== 17'd0) begin
      n_err++;
      $display("FAIL rstmid outputs got=%h exp=0",
               {upd_req, upd_idx, wr_en, wr_idx, busy, frame_done, overrun_cnt, timeout_err});
    end
    n_cmp++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL rstmid quiet cyc=%0d got wr=%b fd=%b busy=%b exp 0", k, wr_en, frame_done, busy);
      end
      n_cmp++;
    end
    start_frame(4'b1111);
    @(negedge clk);
    if (upd_req !== 1'b1 || upd_idx !== 2'd0) begin
      n_err++; $display("FAIL rstmid restart_req got req=%b idx=%0d exp 1/0", upd_req, upd_idx);
    end
    n_cmp++;
    repeat (2) @(negedge clk);
    if (wr_en !== 1'b1 || wr_idx !== 2'd0) begin
      n_err++; $display("FAIL rstmid restart_wr got wr=%b idx=%0d exp 1/0", wr_en, wr_idx);
    end
    n_cmp++;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    if (!seen) begin
      n_err++; $display("FAIL rstmid frame_done_timeout got=0 exp=1 within 40 cycles");
    end
    n_cmp++;
    @(negedge clk);
  endtask

  task automatic test_overrun;
    int exp_ovr;
    exp_ovr = 0;
    @(negedge clk);
    dog_enable = 4'b1111;
    for (int j = 0; j < 450; j++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      if ((j % 3) != 0 && exp_ovr != 255) exp_ovr++;
      if (overrun_cnt !== 8'(exp_ovr)) begin
        n_err++; $display("FAIL overrun tick=%0d got=%0d exp=%0d", j, overrun_cnt, exp_ovr);
      end
      n_cmp++;
      repeat (4) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    if (overrun_cnt !== 8'd255 || busy !== 1'b0) begin
      n_err++; $display("FAIL overrun final got cnt=%0d busy=%b exp 255/0", overrun_cnt, busy);
    end
    n_cmp++;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    skip_idx   = 3'd4;
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    dog_enable = 4'b0000;
    test_reset;
    test_full_mask;
    test_sparse_mask;
    test_empty_mask;
    test_timeout;
    test_reset_mid_frame;
    test_overrun;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dog_update_sched.md
Name: dog_update_sched

Overview:
- Per-frame sequencer for the shared dog physics/bounce datapath.
- On each frame_tick it snapshots the enabled-dog mask and walks the enabled dogs in ascending index order.
- For each dog it requests one update from the single shared update unit via a req/ack + done handshake, then issues a write-back strobe into the dog state registers.
- Sits between the VGA frame-tick generator and the game core's shared update datapath; it guards against stalled updates and counts frame overruns.

Parameters:
- N_DOGS, 4, number of dogs sequenced; range 1..4.
- IDX_W, 2, width of dog index; must satisfy 2**IDX_W >= N_DOGS.
- TIMEOUT, 64, max cycles from entering REQ to seeing upd_done before the dog is skipped.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low; sampled on posedge clk.
- frame_tick  in  1  one-cycle pulse per video frame.
- dog_enable  in  N_DOGS  bit i high = dog i takes part in this frame.
- upd_req  out  1  request to shared update unit.
- upd_idx  out  IDX_W  dog index for the current request; stable while upd_req=1.
- upd_ack  in  1  update unit accepted the request.
- upd_done  in  1  update unit has a result ready for upd_idx.
- wr_en  out  1  one-cycle write-back strobe for the dog state registers.
- wr_idx  out  IDX_W  dog index for wr_en.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse when the frame's sequence completes.
- overrun_cnt  out  8  count of dropped frame_ticks; saturates at 255.
- timeout_err  out  1  sticky; set when any dog update times out.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, pend_mask=0, timer=0.
  - All outputs 0: upd_req, upd_idx, wr_en, wr_idx, busy, frame_done, overrun_cnt, timeout_err.
  - Reset mid-sequence aborts immediately; no wr_en or frame_done is emitted for the aborted frame.
- All outputs are registered.
- States: IDLE, SCAN, REQ, WAIT.
- IDLE:
  - frame_tick=1 with dog_enable!=0: pend_mask<=dog_enable[N_DOGS-1:0]; go to SCAN.
  - frame_tick=1 with dog_enable==0: frame_done pulses next cycle; stay in IDLE.
- SCAN (1 cycle):
  - upd_idx<=index of the lowest set bit of pend_mask.
  - timer<=0; go to REQ.
- REQ:
  - upd_req=1 and upd_idx held.
  - When upd_ack=1 is sampled, upd_req drops in the next cycle and state goes to WAIT.
  - Ack may arrive in the first REQ cycle.
  - upd_done while in REQ is ignored.
- WAIT:
  - upd_req=0.
  - On upd_done=1: next cycle wr_en=1 and wr_idx=upd_idx; the bit is cleared from pend_mask.
  - Then, if the remaining mask is nonzero, state is SCAN in that same next cycle; otherwise state is IDLE and frame_done=1 in that same cycle as wr_en.
  - upd_ack outside REQ is ignored.
- Timer:
  - Increments every cycle in REQ and WAIT.
  - When timer reaches TIMEOUT-1 without upd_done sampled: timeout_err<=1, the dog's bit is cleared, and no wr_en is issued.
  - Sequencing then continues (SCAN or IDLE+frame_done); upd_req is forced low.
  - upd_done and the timeout in the same cycle: done wins, so the write-back happens.
- Overrun: frame_tick while state!=IDLE, including the final WAIT cycle, is dropped and overrun_cnt increments, holding at 255.
- dog_enable changes mid-frame have no effect on the current frame, because the mask is snapshotted.
- Minimum latency: tick sampled at edge 0, then SCAN in cycle 1, REQ (upd_req=1) in cycle 2. With ack in cycle 2 and done in cycle 3, wr_en is asserted in cycle 4. This gives 3 cycles per dog plus 1 for the write-back overlap.

Decomposition:
- Shared package dog_game_pkg holds N_DOGS, IDX_W, the sched_state_t enum (IDLE/SCAN/REQ/WAIT), and the overrun counter width.
- One natural sub-module: dog_prio_enc, a combinational lowest-set-bit encoder from N_DOGS bits to IDX_W.
- Everything else lives in the top module.

Test Plan:
- Mask 4'b1111, responder acks immediately and gives done 1 cycle later -> wr_idx sequence 0,1,2,3 with wr_en at cycles 4,7,10,13; frame_done with the last wr_en; upd_req never high during WAIT.
- Mask 4'b1010 -> only idx 1 then 3 requested; exactly 2 wr_en pulses; frame_done with the idx-3 write; dog_enable changed to 4'b0001 mid-frame has no effect.
- Responder never asserts done for idx 2 (mask 4'b0110) -> timeout_err=1 after 64 cycles in REQ+WAIT; no wr_en for 2; idx 1 written; frame_done still pulses.
- frame_tick every 5 cycles with mask 4'b1111 -> overrun_cnt increments per dropped tick; 300 dropped ticks -> overrun_cnt=255, held.
- Mask 4'b0000 tick -> frame_done 1 cycle later; upd_req and busy stay 0.
- rst_n=0 for 1 cycle during WAIT on idx 1 -> next cycle all outputs 0 and state IDLE; the next tick restarts at idx 0; timeout_err cleared.
